// File: rtl/tile_writer.sv
// Byte-stream tile uploader: a sync/index header followed by 256 row-major pixels
// becomes byte writes into a 4096x8 tile memory, optionally only during blanking.
module tile_writer #(
   parameter logic [3:0] SYNC_NIBBLE = 4'hA,
   parameter bit         BLANK_ONLY  = 1'b1
) (
   input  logic        clk1,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        bright,
   input  logic        abort,
   output logic        wr_en,
   output logic [11:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy,
   output logic        done,
   output logic        err_sync,
   output logic [3:0]  cur_tile
);

   typedef enum logic [1:0] {IDLE, PIX, DONE} state_t;

   state_t     state, state_next;
   logic [7:0] cnt, cnt_next;
   logic [3:0] tile_next;
   logic       xfer;
   logic       hdr_ok;

   always_comb begin
      in_ready = 1'b0;
      case (state)
         IDLE:    in_ready = !abort;
         PIX:     in_ready = !abort && !(BLANK_ONLY && bright);
         default: in_ready = 1'b0;
      endcase
   end

   assign xfer   = in_valid && in_ready;
   assign hdr_ok = (in_data[7:4] == SYNC_NIBBLE);
   assign busy   = (state != IDLE);

   // Abort overrides everything; cnt only wraps on the PIX->DONE transition.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      tile_next  = cur_tile;
      if (abort) begin
         state_next = IDLE;
         cnt_next   = 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer && hdr_ok) begin
                  tile_next  = in_data[3:0];
                  cnt_next   = 8'd0;
                  state_next = PIX;
               end
            end
            PIX: begin
               if (xfer) begin
                  cnt_next = cnt + 8'd1;
                  if (cnt == 8'hFF) state_next = DONE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         cur_tile <= 4'd0;
         wr_en    <= 1'b0;
         wr_addr  <= 12'd0;
         wr_data  <= 8'd0;
         done     <= 1'b0;
         err_sync <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         cur_tile <= tile_next;
         wr_en    <= (state == PIX) && xfer;
         if ((state == PIX) && xfer) begin
            wr_addr <= {cur_tile, cnt};
            wr_data <= in_data;
         end
         // An abort in DONE cancels the pending completion pulse.
         done     <= (state == DONE) && !abort;
         err_sync <= (state == IDLE) && xfer && !hdr_ok;
      end
   end

endmodule

// File: tb/tb_tile_writer.sv
// Directed bench for tile_writer: one blanking-gated instance plus one that
// writes at any time, checked with immediate assertions.
`define CHK(tag, obs, exp) begin total++; assert ((obs) === (exp)) else begin bad++; $error("FAIL %s obs=%0h exp=%0h", tag, (obs), (exp)); end end

module tb_tile_writer;
   logic        clk1 = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic        abort = 1'b0;
   logic        sel0 = 1'b0;
   logic        tog_en = 1'b0;
   logic        bright0 = 1'b1;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   logic        bright, in_ready, wr_en, busy, done, err_sync;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic [3:0]  cur_tile;
   logic        in_ready0, wr_en0, busy0, done0, err_sync0;
   logic [11:0] wr_addr0;
   logic [7:0]  wr_data0;
   logic [3:0]  cur_tile0;
   logic        valid_a, valid_b;

   always #5 clk1 = ~clk1;
   always @(posedge clk1) cyc <= cyc + 1;

   assign bright  = tog_en ? ((cyc % 20) < 10) : 1'b0;
   assign valid_a = in_valid && !sel0;
   assign valid_b = in_valid && sel0;

   tile_writer #(.SYNC_NIBBLE(4'hA), .BLANK_ONLY(1'b1)) dut (
      .clk1(clk1), .rst(rst), .in_data(in_data), .in_valid(valid_a), .in_ready(in_ready),
      .bright(bright), .abort(abort), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err_sync(err_sync), .cur_tile(cur_tile));

   tile_writer #(.SYNC_NIBBLE(4'hA), .BLANK_ONLY(1'b0)) dut0 (
      .clk1(clk1), .rst(rst), .in_data(in_data), .in_valid(valid_b), .in_ready(in_ready0),
      .bright(bright0), .abort(1'b0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
      .busy(busy0), .done(done0), .err_sync(err_sync0), .cur_tile(cur_tile0));

   // Monitor of the blanking-gated instance, sampled mid-cycle.
   logic [11:0] wa [0:2047];
   logic [7:0]  wd [0:2047];
   int wn = 0, dn = 0, bn = 0, en = 0, viol = 0, stall = 0, wn0 = 0;

   always @(negedge clk1) begin
      if (wr_en && wn < 2048) begin
         wa[wn] <= wr_addr;
         wd[wn] <= wr_data;
         wn     <= wn + 1;
      end
      if (done)                       dn    <= dn + 1;
      if (busy)                       bn    <= bn + 1;
      if (err_sync)                   en    <= en + 1;
      if (busy && bright && in_ready) viol  <= viol + 1;
      if (busy && bright)             stall <= stall + 1;
      if (wr_en0)                     wn0   <= wn0 + 1;
   end

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      int   k;
      logic acc;
      in_data  = b;
      in_valid = 1'b1;
      k   = 0;
      acc = 1'b0;
      while (!acc && k < 100) begin
         @(negedge clk1);
         acc = sel0 ? in_ready0 : in_ready;
         @(posedge clk1);
         #1;
         k++;
      end
      `CHK("push_accept", acc, 1'b1)
   endtask

   task automatic upload(input logic [7:0] hdr, input logic [7:0] xv);
      push(hdr);
      for (int i = 0; i < 256; i++) push(8'(i) ^ xv);
      in_valid = 1'b0;
   endtask

   task automatic check_writes(input int base, input logic [3:0] tile, input logic [7:0] xv, input int n);
      int errs;
      int first;
      errs  = 0;
      first = -1;
      for (int i = 0; i < n; i++) begin
         if (wa[base+i] !== {tile, 8'(i)} || wd[base+i] !== (8'(i) ^ xv)) begin
            errs++;
            if (first < 0) first = i;
         end
      end
      `CHK("write_seq_errors", errs, 0)
      if (errs != 0) $display("  first bad write index %0d addr=%0h data=%0h", first, wa[base+first], wd[base+first]);
   endtask

   int base, d0, b0, t0;

   initial begin
      // Reset values
      #2;
      `CHK("rst_in_ready", in_ready, 1'b1)
      `CHK("rst_wr_en", wr_en, 1'b0)
      `CHK("rst_wr_addr", wr_addr, 12'h000)
      `CHK("rst_wr_data", wr_data, 8'h00)
      `CHK("rst_busy", busy, 1'b0)
      `CHK("rst_done", done, 1'b0)
      `CHK("rst_err_sync", err_sync, 1'b0)
      `CHK("rst_cur_tile", cur_tile, 4'h0)
      tick(); tick();
      rst = 1'b1;
      tick();

      // Full tile 3, no stalls
      base = wn; d0 = dn; b0 = bn;
      upload(8'hA3, 8'h00);
      `CHK("t3_last_wr_en", wr_en, 1'b1)
      `CHK("t3_last_addr", wr_addr, 12'h3FF)
      `CHK("t3_busy_done_state", busy, 1'b1)
      `CHK("t3_done_early", done, 1'b0)
      `CHK("t3_ready_in_done", in_ready, 1'b0)
      tick();
      `CHK("t3_done_pulse", done, 1'b1)
      `CHK("t3_busy_after", busy, 1'b0)
      `CHK("t3_ready_back", in_ready, 1'b1)
      `CHK("t3_wr_en_off", wr_en, 1'b0)
      tick();
      `CHK("t3_done_one_cycle", done, 1'b0)
      tick();
      `CHK("t3_write_count", wn - base, 256)
      check_writes(base, 4'h3, 8'h00, 256);
      `CHK("t3_done_count", dn - d0, 1)
      `CHK("t3_busy_cycles", bn - b0, 257)
      $display("tile3 upload: writes=%0d busy_cycles=%0d", wn - base, bn - b0);

      // Bad header, then good header
      base = wn;
      push(8'h53);
      in_valid = 1'b0;
      `CHK("bad_hdr_err", err_sync, 1'b1)
      `CHK("bad_hdr_busy", busy, 1'b0)
      tick();
      `CHK("bad_hdr_err_pulse", err_sync, 1'b0)
      push(8'hA7);
      in_valid = 1'b0;
      `CHK("hdr_a7_tile", cur_tile, 4'h7)
      `CHK("hdr_a7_busy", busy, 1'b1)
      abort = 1'b1;
      tick();
      abort = 1'b0;
      `CHK("a7_abort_idle", busy, 1'b0)
      tick();
      `CHK("bad_hdr_no_writes", wn - base, 0)
      `CHK("bad_hdr_err_count", en, 1)
      $display("bad header 0x53: err_pulses=%0d, then 0xA7 tile=%0d", en, cur_tile);

      // Tile 1 with bright toggling 10/10
      base = wn; d0 = dn;
      tog_en = 1'b1;
      upload(8'hA1, 8'h5A);
      tick(); tick();
      tog_en = 1'b0;
      `CHK("blank_write_count", wn - base, 256)
      check_writes(base, 4'h1, 8'h5A, 256);
      `CHK("blank_ready_violations", viol, 0)
      `CHK("blank_stalled", stall > 0, 1'b1)
      `CHK("blank_done_count", dn - d0, 1)
      $display("tile1 blank-gated upload: writes=%0d stall_cycles=%0d", wn - base, stall);

      // Abort after 100 pixels of tile 2
      base = wn; d0 = dn;
      push(8'hA2);
      for (int i = 0; i < 100; i++) push(8'(i));
      `CHK("ab_pending_wr", wr_en, 1'b1)
      abort   = 1'b1;
      in_data = 8'hEE;
      #1;
      `CHK("ab_ready_low", in_ready, 1'b0)
      @(posedge clk1); #1;
      abort    = 1'b0;
      in_valid = 1'b0;
      `CHK("ab_no_accept", wr_en, 1'b0)
      `CHK("ab_busy_drop", busy, 1'b0)
      tick();
      `CHK("ab_write_count", wn - base, 100)
      check_writes(base, 4'h2, 8'h00, 100);
      `CHK("ab_no_done", dn - d0, 0)
      // Restart tile 2, then abort in DONE to cancel the pulse
      base = wn;
      push(8'hA2);
      for (int i = 0; i < 256; i++) push(8'(i) ^ 8'hC3);
      in_valid = 1'b0;
      `CHK("ab2_in_done", busy, 1'b1)
      abort = 1'b1;
      tick();
      abort = 1'b0;
      `CHK("ab2_done_cancel", done, 1'b0)
      `CHK("ab2_busy", busy, 1'b0)
      tick();
      `CHK("ab2_done_late", done, 1'b0)
      `CHK("ab2_write_count", wn - base, 256)
      check_writes(base, 4'h2, 8'hC3, 256);
      `CHK("ab2_done_count", dn - d0, 0)
      $display("tile2 abort: first run 100 writes, restart at %0h, done pulses=%0d", wa[base], dn - d0);

      // Reset during PIX with a write pending
      push(8'hA4);
      for (int i = 0; i < 3; i++) push(8'(i));
      `CHK("rp_pending", wr_en, 1'b1)
      rst = 1'b0;
      #1;
      `CHK("rp_wr_en", wr_en, 1'b0)
      `CHK("rp_wr_addr", wr_addr, 12'h000)
      `CHK("rp_wr_data", wr_data, 8'h00)
      `CHK("rp_busy", busy, 1'b0)
      `CHK("rp_done", done, 1'b0)
      `CHK("rp_err", err_sync, 1'b0)
      `CHK("rp_cur_tile", cur_tile, 4'h0)
      `CHK("rp_in_ready", in_ready, 1'b1)
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      `CHK("rp_ready_after", in_ready, 1'b1)
      base = wn; d0 = dn;
      upload(8'hA5, 8'h0F);
      tick();
      `CHK("rp_done_pulse", done, 1'b1)
      tick();
      `CHK("rp_write_count", wn - base, 256)
      check_writes(base, 4'h5, 8'h0F, 256);
      `CHK("rp_done_count", dn - d0, 1)
      $display("reset mid-upload, then tile5: writes=%0d", wn - base);

      // Ungated instance, bright held high, tile 15
      sel0 = 1'b1;
      base = wn0;
      push(8'hAF);
      t0 = cyc;
      for (int i = 0; i < 256; i++) push(8'(i));
      in_valid = 1'b0;
      `CHK("nb_last_addr", wr_addr0, 12'hFFF)
      `CHK("nb_last_data", wr_data0, 8'hFF)
      tick();
      `CHK("nb_done", done0, 1'b1)
      `CHK("nb_cycles", cyc - t0 + 1, 258)
      tick();
      `CHK("nb_write_count", wn0 - base, 256)
      sel0 = 1'b0;
      $display("tile15 ungated upload: cycles=%0d writes=%0d", cyc - t0, wn0 - base);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/tile_writer.md
# tile_writer

Loads 16x16-pixel tiles into the tile store from a byte stream. Tiles are later read by the pixel colour path. Each tile upload is a header byte (sync nibble plus tile index) followed by 256 pixel bytes in row-major order. The block turns these into byte-wide writes to the external 4096 x 8 tile memory, and can restrict pixel writes to blanking intervals so the display does not tear.

## Interface
Parameters:
- SYNC_NIBBLE, 4'hA: required value of header bits [7:4].
- BLANK_ONLY, 1: when 1, pixel bytes are accepted only while bright = 0. When 0, bytes are accepted at any time.

Ports:
- clk1  input  1  pixel clock. The only clock.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle. Combinational from state, bright and abort.
- bright  input  1  display active-region flag from the VGA timing block.
- abort  input  1  synchronous abort of the current upload.
- wr_en  output  1  tile memory write strobe, one cycle per pixel.
- wr_addr  output  12  tile memory byte address {tile[3:0], row[3:0], col[3:0]}.
- wr_data  output  8  pixel byte {B[1:0], G[2:0], R[2:0]}, passed through unmodified.
- busy  output  1  upload in progress (state PIX or DONE).
- done  output  1  one-cycle pulse after the 256th write.
- err_sync  output  1  one-cycle pulse when a header byte is rejected.
- cur_tile  output  4  tile index latched from the last accepted header.

## Operation
- A transfer occurs on a rising edge of clk1 when in_valid = 1 and in_ready = 1.
- State IDLE:
  - in_ready = !abort.
  - If the accepted byte has [7:4] = SYNC_NIBBLE: latch cur_tile = byte[3:0], clear the 8-bit pixel counter, go to PIX.
  - Otherwise: drop the byte, pulse err_sync on the next cycle, stay in IDLE.
- State PIX:
  - in_ready = !abort && !(BLANK_ONLY && bright).
  - Each accepted byte registers wr_en = 1, wr_addr = {cur_tile, cnt[7:4], cnt[3:0]}, wr_data = byte, then increments cnt.
  - Row 0, column 0 is the first byte received.
  - Header patterns inside PIX are treated as pixel data; no resync is attempted.
  - Accepting pixel 255 (cnt = 8'hFF) moves the block to DONE.
- State DONE:
  - Lasts exactly one cycle; in_ready = 0.
  - Registered done = 1 on the following cycle, and the block returns to IDLE at the same time.
- abort = 1 at a rising edge (any state):
  - Next state is IDLE and cnt clears; no byte is accepted that cycle.
  - A done already scheduled is cancelled.
  - wr_en already registered from the previous edge still completes.
  - Tile memory contents are left partially written.
- cnt is 8 bits; the wrap from 255 to 0 only happens on the transition to DONE.
- BLANK_ONLY stalls but never drops data. A byte held under bright = 1 is accepted on the first cycle with bright = 0.

## Timing
- Reset values (asynchronous, while rst = 0):
  - state IDLE, cnt 0, cur_tile 0
  - wr_en 0, wr_addr 0, wr_data 0
  - done 0, err_sync 0, busy 0
  - in_ready 1 (idle, abort low)
- Releasing rst mid-upload always restarts in IDLE.
- Write latency: a byte accepted at edge N gives wr_en high in the cycle after edge N, for exactly one cycle.
- Throughput: one pixel per cycle. A full tile with no stalls takes 258 cycles: header, 256 pixels, DONE.
- Timing of the last pixel:
  - The last wr_en and busy = 1 (DONE) are both visible after edge N.
  - done is high after edge N+1, with busy = 0.
  - in_ready returns after edge N+1.
- err_sync and done are registered pulses, never longer than one cycle.
- abort and bright low-to-high are both sampled at the same edge as valid/ready. They take effect on in_ready combinationally within the cycle.

## Test plan
- Header 8'hA3, then pixels 0x00..0xFF with valid held high and bright = 0:
  - 256 writes to addresses 12'h300..12'h3FF with wr_data equal to the low address byte.
  - done pulses once, the cycle after the write to 12'h3FF.
  - busy is high for 257 cycles.
- Header 8'h53:
  - err_sync pulses once, no wr_en, state stays IDLE.
  - A following 8'hA7 is accepted: cur_tile = 7.
- BLANK_ONLY = 1, with bright toggling 10 cycles high / 10 low during an upload to tile 1:
  - in_ready = 0 whenever bright = 1 in PIX.
  - No bytes are lost: 256 writes to 12'h100..12'h1FF, in order.
- abort pulsed after 100 pixels of tile 2:
  - Exactly 100 writes (12'h200..12'h263), no done, busy drops.
  - The next header 8'hA2 restarts at 12'h200.
- rst asserted during PIX, with a write pending:
  - All outputs reach their reset values immediately.
  - After release, in_ready = 1 and a fresh upload completes normally.
- BLANK_ONLY = 0, bright = 1 throughout:
  - The full upload to tile 15 completes in 258 cycles.
  - The last write address is 12'hFFF.
